// File: rtl/axil_cmd_master_if.sv
// AXI4-Lite bus bundle shared by the command master and whatever slave it
// talks to. Carries the five AXI-lite channels:
//   AW : awaddr, awprot, awvalid / awready
//   W  : wdata, wstrb, wvalid / wready
//   B  : bresp, bvalid / bready
//   AR : araddr, arprot, arvalid / arready
//   R  : rdata, rresp, rvalid / rready
// The master modport drives addresses, data, valids and the response readies.
// The slave modport drives the mirror image.
interface axi_lite #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_cmd_master.sv
// Turns a simple valid/ready command stream into single AXI4-Lite reads and
// writes, one transaction outstanding at a time, and returns the result on a
// valid/ready response stream. Any wait state that lasts TIMEOUT cycles is
// abandoned and reported as SLVERR with resp_timeout set.
//
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   cmd_valid / cmd_ready     command handshake (ready only while idle)
//   cmd_write                 1 = write, 0 = read
//   cmd_address, cmd_data     byte address and write data
//   resp_valid / resp_ready   response handshake
//   resp_data                 read data (0 for writes and timeouts)
//   resp_code                 BRESP/RRESP, 2'b10 on timeout
//   resp_timeout              transaction aborted by the wait-cycle limit
//   axil                      AXI4-Lite master port
module axil_cmd_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_address,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [1:0]            resp_code,
  output logic                  resp_timeout,
  axi_lite.master               axil
);

  localparam int CountWidth = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRITE_RESP,
    READ,
    READ_RESP,
    RESPOND
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cmdAddr_q, cmdAddr_d;
  logic [DATA_WIDTH-1:0]   cmdData_q, cmdData_d;
  logic                    awDone_q, awDone_d;
  logic                    wDone_q, wDone_d;
  logic [CountWidth-1:0]   waitCount_q, waitCount_d;
  logic [DATA_WIDTH-1:0]   respData_q, respData_d;
  logic [1:0]              respCode_q, respCode_d;
  logic                    respTimeout_q, respTimeout_d;

  logic awValid;
  logic wValid;
  logic inWait;
  logic waitExpired;
  logic abort;

  // AW and W are tracked independently so each valid falls right after its
  // own handshake while the other may still be waiting.
  assign awValid = (state_q == WRITE) && !awDone_q;
  assign wValid  = (state_q == WRITE) && !wDone_q;
  assign inWait  = (state_q == WRITE) || (state_q == WRITE_RESP) ||
                   (state_q == READ)  || (state_q == READ_RESP);

  // The counter reads 0 in the first cycle of a wait state, so this fires in
  // the TIMEOUT-th waiting cycle, when the count is about to reach TIMEOUT.
  assign waitExpired = (waitCount_q == CountWidth'(TIMEOUT - 1));

  assign cmd_ready    = (state_q == IDLE);
  assign resp_valid   = (state_q == RESPOND);
  assign resp_data    = respData_q;
  assign resp_code    = respCode_q;
  assign resp_timeout = respTimeout_q;

  assign axil.awaddr  = cmdAddr_q;
  assign axil.awprot  = 3'b000;
  assign axil.awvalid = awValid;
  assign axil.wdata   = cmdData_q;
  assign axil.wstrb   = '1;
  assign axil.wvalid  = wValid;
  assign axil.bready  = (state_q == WRITE_RESP);
  assign axil.araddr  = cmdAddr_q;
  assign axil.arprot  = 3'b000;
  assign axil.arvalid = (state_q == READ);
  assign axil.rready  = (state_q == READ_RESP);

  // Next-state logic. A completed handshake takes priority over an expiring
  // wait counter in the same cycle, so a late but valid answer is kept.
  always_comb begin
    state_d       = state_q;
    cmdAddr_d     = cmdAddr_q;
    cmdData_d     = cmdData_q;
    awDone_d      = awDone_q;
    wDone_d       = wDone_q;
    waitCount_d   = waitCount_q;
    respData_d    = respData_q;
    respCode_d    = respCode_q;
    respTimeout_d = respTimeout_q;
    abort         = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmdAddr_d     = cmd_address;
          cmdData_d     = cmd_data;
          awDone_d      = 1'b0;
          wDone_d       = 1'b0;
          respTimeout_d = 1'b0;
          state_d       = cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        awDone_d = awDone_q | (awValid & axil.awready);
        wDone_d  = wDone_q  | (wValid  & axil.wready);
        if (awDone_d && wDone_d) begin
          state_d = WRITE_RESP;
        end else if (waitExpired) begin
          abort = 1'b1;
        end
      end
      WRITE_RESP: begin
        if (axil.bvalid) begin
          respCode_d = axil.bresp;
          respData_d = '0;
          state_d    = RESPOND;
        end else if (waitExpired) begin
          abort = 1'b1;
        end
      end
      READ: begin
        if (axil.arready) begin
          state_d = READ_RESP;
        end else if (waitExpired) begin
          abort = 1'b1;
        end
      end
      READ_RESP: begin
        if (axil.rvalid) begin
          respCode_d = axil.rresp;
          respData_d = axil.rdata;
          state_d    = RESPOND;
        end else if (waitExpired) begin
          abort = 1'b1;
        end
      end
      RESPOND: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d       = RESPOND;
      respCode_d    = 2'b10;
      respTimeout_d = 1'b1;
      respData_d    = '0;
    end

    // Every state change restarts the count; only wait states advance it.
    if (state_d != state_q) begin
      waitCount_d = '0;
    end else if (inWait) begin
      waitCount_d = waitCount_q + 1'b1;
    end
  end

  // State register. Reset wins over anything the bus does in the same cycle
  // and drops an in-flight transaction without producing a response.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      cmdAddr_q     <= '0;
      cmdData_q     <= '0;
      awDone_q      <= 1'b0;
      wDone_q       <= 1'b0;
      waitCount_q   <= '0;
      respData_q    <= '0;
      respCode_q    <= 2'b00;
      respTimeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmdAddr_q     <= cmdAddr_d;
      cmdData_q     <= cmdData_d;
      awDone_q      <= awDone_d;
      wDone_q       <= wDone_d;
      waitCount_q   <= waitCount_d;
      respData_q    <= respData_d;
      respCode_q    <= respCode_d;
      respTimeout_q <= respTimeout_d;
    end
  end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Self-checking bench for axil_cmd_master: a behavioural AXI-lite slave with
// adjustable per-channel delays, a reference memory that predicts read data,
// and a response scoreboard fed when commands are driven.
module tb_axil_cmd_master;

  localparam int AddrW = 32;
  localparam int DataW = 32;
  localparam int TimeoutCycles = 15;
  localparam logic [31:0] BaseAddr = 32'h4400_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmdValid;
  logic        cmdReady;
  logic        cmdWrite;
  logic [31:0] cmdAddress;
  logic [31:0] cmdData;
  logic        respValid;
  logic        respReady;
  logic [31:0] respData;
  logic [1:0]  respCode;
  logic        respTimeout;

  int vecCount = 0;
  int missCount = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  code;
    logic        timeout;
  } resp_t;

  resp_t expQ[$];
  logic [31:0] refMem [0:63];
  logic [31:0] slaveMem [0:63];

  always #5 clock = ~clock;

  axi_lite #(.ADDR_WIDTH(AddrW), .DATA_WIDTH(DataW)) axilBus ();

  axil_cmd_master #(
    .ADDR_WIDTH(AddrW),
    .DATA_WIDTH(DataW),
    .TIMEOUT(TimeoutCycles)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cmd_valid(cmdValid),
    .cmd_ready(cmdReady),
    .cmd_write(cmdWrite),
    .cmd_address(cmdAddress),
    .cmd_data(cmdData),
    .resp_valid(respValid),
    .resp_ready(respReady),
    .resp_data(respData),
    .resp_code(respCode),
    .resp_timeout(respTimeout),
    .axil(axilBus)
  );

  // Slave knobs, changed by the stimulus between transactions.
  int         awDelay = 0;
  int         wDelay = 0;
  int         bDelay = 0;
  int         rDelay = 0;
  logic       arNever = 1'b0;
  logic [1:0] slaveResp = 2'b00;
  int         bCount = 0;

  int          awCnt, wCnt, bCnt, rCnt;
  logic        awGot, wGot, bPend, rPend;
  logic [31:0] awAddrLat, wDataLat, rDataLat;
  logic        awHs, wHs, bHs, arHs, rHs;
  logic [5:0]  slvWrIdx;
  logic [31:0] slvWrData;

  assign axilBus.awready = axilBus.awvalid && !awGot && (awCnt >= awDelay);
  assign axilBus.wready  = axilBus.wvalid && !wGot && (wCnt >= wDelay);
  assign axilBus.bvalid  = bPend && (bCnt >= bDelay);
  assign axilBus.bresp   = slaveResp;
  assign axilBus.arready = axilBus.arvalid && !arNever && !rPend;
  assign axilBus.rvalid  = rPend && (rCnt >= rDelay);
  assign axilBus.rdata   = rDataLat;
  assign axilBus.rresp   = slaveResp;

  assign awHs = axilBus.awvalid && axilBus.awready;
  assign wHs  = axilBus.wvalid && axilBus.wready;
  assign bHs  = axilBus.bvalid && axilBus.bready;
  assign arHs = axilBus.arvalid && axilBus.arready;
  assign rHs  = axilBus.rvalid && axilBus.rready;
  assign slvWrIdx  = awHs ? axilBus.awaddr[7:2] : awAddrLat[7:2];
  assign slvWrData = wHs ? axilBus.wdata : wDataLat;

  // Behavioural slave: ready after a programmable number of waiting cycles,
  // B/R answers a programmable number of cycles after the request lands.
  always @(posedge clock) begin
    if (reset) begin
      awCnt <= 0;
      wCnt  <= 0;
      bCnt  <= 0;
      rCnt  <= 0;
      awGot <= 1'b0;
      wGot  <= 1'b0;
      bPend <= 1'b0;
      rPend <= 1'b0;
    end else begin
      awCnt <= (axilBus.awvalid && !axilBus.awready) ? awCnt + 1 : 0;
      wCnt  <= (axilBus.wvalid && !axilBus.wready) ? wCnt + 1 : 0;
      if (bPend) begin
        if (bHs) begin
          bPend  <= 1'b0;
          bCount <= bCount + 1;
        end else begin
          bCnt <= bCnt + 1;
        end
      end
      if (awHs) begin
        awGot     <= 1'b1;
        awAddrLat <= axilBus.awaddr;
      end
      if (wHs) begin
        wGot     <= 1'b1;
        wDataLat <= axilBus.wdata;
      end
      if ((awGot || awHs) && (wGot || wHs)) begin
        slaveMem[slvWrIdx] <= slvWrData;
        awGot <= 1'b0;
        wGot  <= 1'b0;
        bPend <= 1'b1;
        bCnt  <= 0;
      end
      if (rPend) begin
        if (rHs) rPend <= 1'b0;
        else rCnt <= rCnt + 1;
      end
      if (arHs) begin
        rPend    <= 1'b1;
        rCnt     <= 0;
        rDataLat <= slaveMem[axilBus.araddr[7:2]];
      end
    end
  end

  task checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Response scoreboard: a handshake seen at the negedge completes on the
  // next rising edge, so the oldest prediction is retired here.
  always @(negedge clock) begin
    if (!reset && respValid && respReady) begin
      if (expQ.size() == 0) begin
        checkOutput("spuriousResp", 64'(respValid), 64'(0));
      end else begin
        resp_t e;
        e = expQ.pop_front();
        checkOutput("respData", 64'(respData), 64'(e.data));
        checkOutput("respCode", 64'(respCode), 64'(e.code));
        checkOutput("respTimeout", 64'(respTimeout), 64'(e.timeout));
      end
    end
  end

  task tick();
    @(posedge clock);
    #1;
  endtask

  // Waits for the master to go idle, drives one command for one accepted
  // cycle and records what the response should be. Returns one cycle after
  // the command handshake.
  task applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                     input logic expTimeout);
    resp_t e;
    int guard;
    guard = 0;
    while (!cmdReady && guard < 60) begin
      tick();
      guard++;
    end
    checkOutput("cmdReadyWait", 64'(cmdReady), 64'(1));
    cmdValid   = 1'b1;
    cmdWrite   = wr;
    cmdAddress = addr;
    cmdData    = data;
    e.timeout  = expTimeout;
    e.code     = expTimeout ? 2'b10 : slaveResp;
    if (wr) begin
      e.data = 32'h0;
      if (!expTimeout) refMem[addr[7:2]] = data;
    end else begin
      e.data = expTimeout ? 32'h0 : refMem[addr[7:2]];
    end
    expQ.push_back(e);
    tick();
    cmdValid = 1'b0;
  endtask

  task waitResponses(input int budget);
    int guard;
    guard = 0;
    while (!(expQ.size() == 0 && cmdReady) && guard < budget) begin
      tick();
      guard++;
    end
    checkOutput("drainDone", 64'(expQ.size()), 64'(0));
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: time %0t, expected finish before 400000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] heldData;
    int arCycles;
    int bBefore;
    int guard;

    for (int i = 0; i < 64; i++) begin
      slaveMem[i] = 32'h0101_0101 * i;
      refMem[i]   = 32'h0101_0101 * i;
    end
    reset      = 1'b1;
    cmdValid   = 1'b0;
    cmdWrite   = 1'b0;
    cmdAddress = '0;
    cmdData    = '0;
    respReady  = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    checkOutput("rstCmdReady", 64'(cmdReady), 64'(1));
    checkOutput("rstRespValid", 64'(respValid), 64'(0));
    checkOutput("rstRespData", 64'(respData), 64'(0));
    checkOutput("rstRespCode", 64'(respCode), 64'(0));
    checkOutput("rstRespTimeout", 64'(respTimeout), 64'(0));
    checkOutput("rstAxiCtl", 64'({axilBus.awvalid, axilBus.wvalid, axilBus.bready,
                                  axilBus.arvalid, axilBus.rready}), 64'(0));

    // Minimum-latency write
    applyStimulus(1'b1, BaseAddr, 32'h0000_CAFE, 1'b0);
    checkOutput("wrValidsN1", 64'({axilBus.awvalid, axilBus.wvalid}), 64'(2'b11));
    checkOutput("wrAwaddr", 64'(axilBus.awaddr), 64'(BaseAddr));
    checkOutput("wrWdata", 64'(axilBus.wdata), 64'(32'h0000_CAFE));
    checkOutput("wrStrbProt", 64'({axilBus.wstrb, axilBus.awprot}), 64'(7'b1111_000));
    checkOutput("wrCmdReadyN1", 64'(cmdReady), 64'(0));
    tick();
    checkOutput("wrValidsN2", 64'({axilBus.awvalid, axilBus.wvalid}), 64'(0));
    checkOutput("wrBreadyN2", 64'(axilBus.bready), 64'(1));
    tick();
    checkOutput("wrRespValidN3", 64'(respValid), 64'(1));
    waitResponses(50);

    // Minimum-latency read of the same word
    applyStimulus(1'b0, BaseAddr, 32'h0, 1'b0);
    checkOutput("rdArvalidN1", 64'(axilBus.arvalid), 64'(1));
    checkOutput("rdAraddr", 64'(axilBus.araddr), 64'(BaseAddr));
    checkOutput("rdArprot", 64'(axilBus.arprot), 64'(0));
    tick();
    checkOutput("rdRreadyN2", 64'({axilBus.arvalid, axilBus.rready}), 64'(2'b01));
    tick();
    checkOutput("rdRespValidN3", 64'(respValid), 64'(1));
    waitResponses(50);

    // Random mix with random slave delays and response codes
    for (int n = 0; n < 12; n++) begin
      logic [2:0] idx;
      logic wr;
      awDelay   = $urandom_range(0, 4);
      wDelay    = $urandom_range(0, 4);
      bDelay    = $urandom_range(0, 4);
      rDelay    = $urandom_range(0, 4);
      slaveResp = 2'($urandom_range(0, 3));
      idx       = 3'($urandom_range(0, 7));
      wr        = 1'($urandom_range(0, 1));
      applyStimulus(wr, BaseAddr + {27'h0, idx, 2'b00}, $urandom, 1'b0);
      waitResponses(80);
    end
    awDelay = 0; wDelay = 0; bDelay = 0; rDelay = 0; slaveResp = 2'b00;

    // W accepted three cycles before AW
    awDelay = 3;
    bBefore = bCount;
    applyStimulus(1'b1, BaseAddr + 32'h10, 32'h5A5A_0001, 1'b0);
    checkOutput("skewValidsN1", 64'({axilBus.awvalid, axilBus.wvalid}), 64'(2'b11));
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("skewWvalidLow", 64'(axilBus.wvalid), 64'(0));
      checkOutput("skewAwvalidHeld", 64'(axilBus.awvalid), 64'(1));
      checkOutput("skewAwaddrHeld", 64'(axilBus.awaddr), 64'(BaseAddr + 32'h10));
    end
    tick();
    checkOutput("skewAwDone", 64'({axilBus.awvalid, axilBus.bready}), 64'(2'b01));
    waitResponses(50);
    checkOutput("skewBCount", 64'(bCount - bBefore), 64'(1));
    awDelay = 0;

    // Read that the slave never accepts
    arNever = 1'b1;
    applyStimulus(1'b0, BaseAddr + 32'h14, 32'h0, 1'b1);
    arCycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (!axilBus.arvalid) break;
      arCycles++;
      tick();
    end
    checkOutput("toArvalidCycles", 64'(arCycles), 64'(TimeoutCycles));
    checkOutput("toRready", 64'(axilBus.rready), 64'(0));
    checkOutput("toRespValid", 64'(respValid), 64'(1));
    tick();
    checkOutput("toFlagHeldIdle", 64'({respTimeout, cmdReady}), 64'(2'b11));
    arNever = 1'b0;
    applyStimulus(1'b0, BaseAddr + 32'h14, 32'h0, 1'b0);
    checkOutput("toFlagCleared", 64'(respTimeout), 64'(0));
    waitResponses(50);

    // Response held back by resp_ready, next command waiting behind it
    respReady = 1'b0;
    heldData  = refMem[3];
    applyStimulus(1'b0, BaseAddr + 32'hC, 32'h0, 1'b0);
    cmdValid   = 1'b1;
    cmdWrite   = 1'b1;
    cmdAddress = BaseAddr + 32'h18;
    cmdData    = 32'h1234_5678;
    begin
      resp_t e;
      e.data = 32'h0; e.code = 2'b00; e.timeout = 1'b0;
      expQ.push_back(e);
      refMem[6] = 32'h1234_5678;
    end
    guard = 0;
    while (!respValid && guard < 20) begin
      tick();
      guard++;
    end
    checkOutput("holdRespValid", 64'(respValid), 64'(1));
    for (int k = 0; k < 10; k++) begin
      tick();
      checkOutput("holdValid", 64'(respValid), 64'(1));
      checkOutput("holdData", 64'(respData), 64'(heldData));
      checkOutput("holdCmdReady", 64'(cmdReady), 64'(0));
    end
    respReady = 1'b1;
    tick();
    checkOutput("holdIdleAfterHs", 64'({cmdReady, respValid}), 64'(2'b10));
    tick();
    checkOutput("holdNextAccepted", 64'({cmdReady, axilBus.awvalid}), 64'(2'b01));
    cmdValid = 1'b0;
    waitResponses(50);

    // Reset while waiting for B
    bDelay = 5;
    applyStimulus(1'b1, BaseAddr + 32'h1C, 32'hDEAD_BEEF, 1'b0);
    tick();
    checkOutput("rstMidBready", 64'(axilBus.bready), 64'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expQ.delete();
    checkOutput("rstMidAfter", 64'({axilBus.bready, respValid, cmdReady}), 64'(3'b001));
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput("rstMidNoResp", 64'(respValid), 64'(0));
    end
    bDelay = 0;
    applyStimulus(1'b0, BaseAddr + 32'h1C, 32'h0, 1'b0);
    waitResponses(50);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
